// File: rtl/ext_mem_router.sv
// ext_mem_router: decodes the CPU bus into NUM_REGIONS channels, with per-region minimum wait states, stall and timeout.
// Latency: request in T, strobe T+1..T+1+w, DONE at T+2+w (minimum 2 cycles); decode errors reach DONE at T+1.
// Backpressure: needWait_o stalls the CPU until DONE; chan_needWait_i[sel] extends the strobe up to TIMEOUT cycles.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   addr_i, re_i, we_i, wdata_i CPU request; sampled only in IDLE
//   rdata_o, needWait_o         CPU read data (valid in DONE) and stall
//   bus_err_o, err_addr_o,      error pulse in DONE, last errored address,
//   err_count_o                 saturating error count
//   chan_addr_o, chan_wdata_o   registered local address and write data, shared by all channels
//   chan_re_o, chan_we_o        one-hot channel strobes
//   chan_rdata_i, chan_needWait_i  per-channel read data and stall
module ext_mem_router #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int REGION_BITS = 3,
  parameter int NUM_REGIONS = 4,
  parameter logic [4*(2**REGION_BITS)-1:0] WAIT_CYCLES = 'h0012,
  parameter int TIMEOUT     = 64,
  localparam int LOCAL_W    = ADDR_W - REGION_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic                          re_i,
  input  logic                          we_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          needWait_o,
  output logic                          bus_err_o,
  output logic [ADDR_W-1:0]             err_addr_o,
  output logic [7:0]                    err_count_o,
  output logic [LOCAL_W-1:0]            chan_addr_o,
  output logic [DATA_W-1:0]             chan_wdata_o,
  output logic [NUM_REGIONS-1:0]        chan_re_o,
  output logic [NUM_REGIONS-1:0]        chan_we_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] chan_rdata_i,
  input  logic [NUM_REGIONS-1:0]        chan_needWait_i
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                   state_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [REGION_BITS-1:0]   sel_q;
  logic                     is_wr_q;
  logic [3:0]               wait_cnt_q;
  logic [TW-1:0]            tmo_cnt_q;
  logic [DATA_W-1:0]        rdata_q;
  logic [NUM_REGIONS-1:0]   re_q;
  logic [NUM_REGIONS-1:0]   we_q;
  logic                     bus_err_q;
  logic [ADDR_W-1:0]        err_addr_q;
  logic [7:0]               err_cnt_q;

  // Request decode (IDLE) and selected-channel muxes (ACCESS).
  logic [REGION_BITS-1:0]   req_sel_d;
  logic                     req_bad_d;
  logic [NUM_REGIONS-1:0]   req_onehot_d;
  logic [3:0]               cur_wait_d;
  logic [DATA_W-1:0]        cur_rdata_d;
  logic                     cur_nw_d;
  logic                     access_ok_d;

  assign req_sel_d = addr_i[ADDR_W-1 -: REGION_BITS];
  assign req_bad_d = (re_i & we_i) | (int'(req_sel_d) >= NUM_REGIONS);

  // Loop-based muxes keep unmapped selects from indexing past the channel vectors.
  always_comb begin
    req_onehot_d = '0;
    cur_wait_d   = '0;
    cur_rdata_d  = '0;
    cur_nw_d     = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      req_onehot_d[i] = (int'(req_sel_d) == i);
      if (int'(sel_q) == i) begin
        cur_wait_d  = WAIT_CYCLES[4*i +: 4];
        cur_rdata_d = chan_rdata_i[DATA_W*i +: DATA_W];
        cur_nw_d    = chan_needWait_i[i];
      end
    end
  end

  assign access_ok_d = (wait_cnt_q >= cur_wait_d) && !cur_nw_d;

  // The stall must be combinational in IDLE so the CPU holds in the request cycle.
  assign needWait_o = (state_q == S_ACCESS) | ((state_q == S_IDLE) & (re_i | we_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      is_wr_q    <= 1'b0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rdata_q    <= '0;
      re_q       <= '0;
      we_q       <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (re_i | we_i) begin
            addr_q     <= addr_i;
            wdata_q    <= wdata_i;
            sel_q      <= req_sel_d;
            is_wr_q    <= we_i;
            wait_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            if (req_bad_d) begin
              // Unmapped or read+write: no strobe, report in the following DONE cycle.
              state_q    <= S_DONE;
              bus_err_q  <= 1'b1;
              err_addr_q <= addr_i;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
              state_q <= S_ACCESS;
              if (we_i) we_q <= req_onehot_d;
              else      re_q <= req_onehot_d;
            end
          end
        end
        S_ACCESS: begin
          // Saturates at 15, the largest programmable wait, so compare stays valid.
          if (wait_cnt_q != 4'hF) wait_cnt_q <= wait_cnt_q + 4'd1;
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (access_ok_d) begin
            re_q    <= '0;
            we_q    <= '0;
            state_q <= S_DONE;
            if (!is_wr_q) rdata_q <= cur_rdata_d;
          end else if (tmo_cnt_q == TW'(TIMEOUT-1)) begin
            re_q       <= '0;
            we_q       <= '0;
            rdata_q    <= '1;
            bus_err_q  <= 1'b1;
            err_addr_q <= addr_q;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            state_q    <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata_o      = rdata_q;
  assign bus_err_o    = bus_err_q;
  assign err_addr_o   = err_addr_q;
  assign err_count_o  = err_cnt_q;
  assign chan_addr_o  = addr_q[LOCAL_W-1:0];
  assign chan_wdata_o = wdata_q;
  assign chan_re_o    = re_q;
  assign chan_we_o    = we_q;

endmodule
